// File: rtl/tlul_host_adapter.sv
// ---------------------------------------------------------------------------
// tlul_host_adapter
//
// Turns a simple valid/ready request/response interface into TL-UL A/D
// channel traffic. Up to MaxOutstanding transactions may be in flight. Each
// one is tracked by its source ID, and responses may return in any order.
// The A beat carries command and data integrity. Writes may be byte-masked.
//
// The file also carries minimal top_pkg / tlul_pkg definitions, so the block
// builds on its own.
//
// Optional feature: define TLUL_HOST_ADAPTER_TIMEOUT_EN to add a watchdog.
// The watchdog raises timeout_o once TimeoutCycles cycles pass with work in
// flight and no D beat accepted. It does not abort anything.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_valid_i/ready_o   request handshake
//   req_we_i              1 = write, 0 = read
//   req_addr_i            byte address, DBW-aligned
//   req_wdata_i/req_be_i  write data and byte enables
//   rsp_valid_o/ready_i   response handshake (combinational from D channel)
//   rsp_rdata_o/err_o     d_data / d_error
//   rsp_source_o          source ID of the completing transaction
//   tl_o / tl_i           TL-UL host-to-device / device-to-host structs
//   outstanding_o         number of transactions in flight
//   err_unexp_o           one-cycle pulse for a D beat with no pending source
//   timeout_o             sticky watchdog flag (0 unless the feature is on)
// ---------------------------------------------------------------------------
package top_pkg;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_SZW = 2;
endpackage

package tlul_pkg;
  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  localparam logic [3:0] MuBi4False = 4'h9;

  typedef struct packed {
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  localparam tl_a_user_t TL_A_USER_DEFAULT = '{
    instr_type: MuBi4False, cmd_intg: 7'h0, data_intg: 7'h0};

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic                         a_valid;
    tl_a_op_e                     a_opcode;
    logic [2:0]                   a_param;
    logic [top_pkg::TL_SZW-1:0]   a_size;
    logic [top_pkg::TL_AIW-1:0]   a_source;
    logic [top_pkg::TL_AW-1:0]    a_address;
    logic [top_pkg::TL_DBW-1:0]   a_mask;
    logic [top_pkg::TL_DW-1:0]    a_data;
    tl_a_user_t                   a_user;
    logic                         d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                         d_valid;
    tl_d_op_e                     d_opcode;
    logic [2:0]                   d_param;
    logic [top_pkg::TL_SZW-1:0]   d_size;
    logic [top_pkg::TL_AIW-1:0]   d_source;
    logic [top_pkg::TL_DIW-1:0]   d_sink;
    logic [top_pkg::TL_DW-1:0]    d_data;
    tl_d_user_t                   d_user;
    logic                         d_error;
    logic                         a_ready;
  } tl_d2h_t;

  // Hamming-style 7-bit check code. Check bit k covers the bits whose
  // (index+1) has bit k set. Bit 6 is overall parity.
  function automatic logic [6:0] calc_intg(input logic [63:0] vec);
    logic [6:0] chk;
    logic [5:0] pos;
    chk = '0;
    for (int i = 0; i < 64; i++) begin
      pos = 6'(i + 1);
      for (int k = 0; k < 6; k++) begin
        if (pos[k]) chk[k] = chk[k] ^ vec[i];
      end
      chk[6] = chk[6] ^ vec[i];
    end
    return chk;
  endfunction

  function automatic logic [6:0] get_data_intg(input logic [top_pkg::TL_DW-1:0] data);
    return calc_intg(64'(data));
  endfunction

  // Covers the command-carrying fields of the A beat.
  function automatic logic [6:0] get_cmd_intg(input tl_h2d_t tl);
    return calc_intg(64'({tl.a_user.instr_type, tl.a_address, tl.a_opcode, tl.a_mask}));
  endfunction
endpackage

module tlul_host_adapter #(
  parameter int TL_AW          = top_pkg::TL_AW,
  parameter int TL_DW          = top_pkg::TL_DW,
  parameter int MaxOutstanding = 4,
  parameter int TimeoutCycles  = 1024,
  localparam int DBW           = TL_DW / 8,
  localparam int SrcW          = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [TL_AW-1:0]    req_addr_i,
  input  logic [TL_DW-1:0]    req_wdata_i,
  input  logic [DBW-1:0]      req_be_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [TL_DW-1:0]    rsp_rdata_o,
  output logic                rsp_err_o,
  output logic [SrcW-1:0]     rsp_source_o,
  output tlul_pkg::tl_h2d_t   tl_o,
  input  tlul_pkg::tl_d2h_t   tl_i,
  output logic [SrcW:0]       outstanding_o,
  output logic                err_unexp_o,
  output logic                timeout_o
);

  typedef enum logic {A_IDLE, A_HOLD} a_state_e;

  localparam int AIW     = top_pkg::TL_AIW;
  localparam int SzW     = top_pkg::TL_SZW;
  localparam int SizeLog = $clog2(DBW);

  a_state_e                aState_q;
  tlul_pkg::tl_h2d_t       aBeat_q, aBeat_d;
  logic [MaxOutstanding-1:0] pending_q, pending_d;
  logic [SrcW:0]           outstanding_q, outstanding_d;
  logic                    errUnexp_q;
  logic [SrcW-1:0]         freeIdx;
  logic                    freeFound;
  logic [MaxOutstanding-1:0] dSel, setMask, clrMask;
  logic                    dHit, dReady, dAccept, reqReady, accept;

  // Pick the lowest-index free source. A source that retires this cycle still
  // looks busy here, so it cannot be reused until the next cycle.
  always_comb begin
    freeIdx   = '0;
    freeFound = 1'b0;
    for (int i = 0; i < MaxOutstanding; i++) begin
      if (!pending_q[i] && !freeFound) begin
        freeIdx   = SrcW'(i);
        freeFound = 1'b1;
      end
    end
  end

  // Decode d_source against the full ID width. A beat whose upper source bits
  // are set can never hit, so it is treated as unexpected and dropped.
  always_comb begin
    dSel = '0;
    for (int i = 0; i < MaxOutstanding; i++) begin
      dSel[i] = (tl_i.d_source == AIW'(i));
    end
  end

  assign dHit     = |(dSel & pending_q);
  assign dReady   = dHit ? rsp_ready_i : 1'b1;
  assign dAccept  = tl_i.d_valid & dReady;
  assign clrMask  = dAccept ? (dSel & pending_q) : '0;

  // In A_HOLD, a new request can only be taken when the held beat leaves.
  assign reqReady = !rst_i && freeFound && ((aState_q == A_IDLE) || tl_i.a_ready);
  assign accept   = req_valid_i & reqReady;

  // Build the mask of the source taken by this cycle's accepted request.
  always_comb begin
    setMask = '0;
    for (int i = 0; i < MaxOutstanding; i++) begin
      setMask[i] = accept && (freeIdx == SrcW'(i));
    end
  end

  assign pending_d     = (pending_q & ~clrMask) | setMask;
  assign outstanding_d = outstanding_q + (SrcW+1)'(accept) - (SrcW+1)'(|clrMask);

  // Encode the next A beat. Data integrity is computed first because the
  // command integrity is taken over the finished beat.
  always_comb begin
    aBeat_d           = '0;
    aBeat_d.a_valid   = 1'b1;
    aBeat_d.a_size    = SzW'(SizeLog);
    aBeat_d.a_source  = AIW'(freeIdx);
    aBeat_d.a_address = req_addr_i;
    aBeat_d.d_ready   = 1'b1;
    if (!req_we_i) begin
      aBeat_d.a_opcode = tlul_pkg::Get;
      aBeat_d.a_mask   = '1;
      aBeat_d.a_data   = '0;
    end else begin
      aBeat_d.a_opcode = (&req_be_i) ? tlul_pkg::PutFullData : tlul_pkg::PutPartialData;
      aBeat_d.a_mask   = req_be_i;
      aBeat_d.a_data   = req_wdata_i;
    end
    aBeat_d.a_user           = tlul_pkg::TL_A_USER_DEFAULT;
    aBeat_d.a_user.data_intg = tlul_pkg::get_data_intg(aBeat_d.a_data);
    aBeat_d.a_user.cmd_intg  = tlul_pkg::get_cmd_intg(aBeat_d);
  end

  // A-channel FSM plus source tracking. The held beat stays frozen until
  // a_ready. Reset drops the pending state and the held beat together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aState_q       <= A_IDLE;
      aBeat_q        <= '0;
      aBeat_q.a_user <= tlul_pkg::TL_A_USER_DEFAULT;
      aBeat_q.d_ready <= 1'b1;
      pending_q      <= '0;
      outstanding_q  <= '0;
      errUnexp_q     <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      errUnexp_q    <= tl_i.d_valid & ~dHit;
      case (aState_q)
        A_IDLE: begin
          if (accept) begin
            aBeat_q  <= aBeat_d;
            aState_q <= A_HOLD;
          end
        end
        A_HOLD: begin
          if (tl_i.a_ready) begin
            if (accept) begin
              aBeat_q <= aBeat_d;
            end else begin
              aBeat_q.a_valid <= 1'b0;
              aState_q        <= A_IDLE;
            end
          end
        end
        default: aState_q <= A_IDLE;
      endcase
    end
  end

  // The A fields come from registers. d_ready follows the live D beat.
  always_comb begin
    tl_o         = aBeat_q;
    tl_o.d_ready = dReady;
  end

  assign req_ready_o   = reqReady;
  assign rsp_valid_o   = tl_i.d_valid & dHit;
  assign rsp_rdata_o   = tl_i.d_data;
  assign rsp_err_o     = tl_i.d_error;
  assign rsp_source_o  = tl_i.d_source[SrcW-1:0];
  assign outstanding_o = outstanding_q;
  assign err_unexp_o   = errUnexp_q;

  logic unused_dFields;
  assign unused_dFields = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size,
                            tl_i.d_sink, tl_i.d_user};

`ifdef TLUL_HOST_ADAPTER_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] toCnt_q, toCnt_d;
  logic            timeout_q;

  // Count idle-response cycles while work is in flight. Saturate at the limit.
  always_comb begin
    toCnt_d = toCnt_q;
    if ((outstanding_q == '0) || dAccept) begin
      toCnt_d = '0;
    end else if (toCnt_q != CntW'(TimeoutCycles)) begin
      toCnt_d = toCnt_q + CntW'(1);
    end
  end

  // The flag stays set until reset, and nothing in flight is touched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      toCnt_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      toCnt_q   <= toCnt_d;
      timeout_q <= timeout_q | (toCnt_d == CntW'(TimeoutCycles));
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TimeoutCycles != 0);
  assign timeout_o      = 1'b0;
`endif

endmodule

// File: tb/tb_tlul_host_adapter.sv
// ---------------------------------------------------------------------------
// tb_tlul_host_adapter
//
// Testbench for tlul_host_adapter. A table of single transactions runs first.
// Hand-written sequences then cover back-to-back issue, full-table stall,
// out-of-order retire, A-channel back-pressure, unexpected D beats, reset in
// mid-flight and the watchdog (TLUL_HOST_ADAPTER_TIMEOUT_EN).
// ---------------------------------------------------------------------------
module tb_tlul_host_adapter;

  typedef struct {
    logic               we;
    logic [31:0]        addr;
    logic [31:0]        wdata;
    logic [3:0]         be;
    tlul_pkg::tl_a_op_e expOp;
    logic [3:0]         expMask;
    logic [31:0]        expData;
    logic [31:0]        rdata;
    logic               err;
  } vec_t;

  logic              clk;
  logic              rst;
  logic              reqValid, reqReady, reqWe;
  logic [31:0]       reqAddr, reqWdata;
  logic [3:0]        reqBe;
  logic              rspValid, rspReady, rspErr;
  logic [31:0]       rspRdata;
  logic [1:0]        rspSource;
  tlul_pkg::tl_h2d_t tlH2d;
  tlul_pkg::tl_d2h_t tlD2h;
  logic [2:0]        outstanding;
  logic              errUnexp, timeout;

  int checks   = 0;
  int failures = 0;

  vec_t              vecs[5];
  tlul_pkg::tl_h2d_t expBeat;
  int                drainOrder[4];

  tlul_host_adapter #(
    .MaxOutstanding(4),
    .TimeoutCycles (16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (reqValid),
    .req_ready_o  (reqReady),
    .req_we_i     (reqWe),
    .req_addr_i   (reqAddr),
    .req_wdata_i  (reqWdata),
    .req_be_i     (reqBe),
    .rsp_valid_o  (rspValid),
    .rsp_ready_i  (rspReady),
    .rsp_rdata_o  (rspRdata),
    .rsp_err_o    (rspErr),
    .rsp_source_o (rspSource),
    .tl_o         (tlH2d),
    .tl_i         (tlD2h),
    .outstanding_o(outstanding),
    .err_unexp_o  (errUnexp),
    .timeout_o    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic valid, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
    reqValid = valid;
    reqWe    = we;
    reqAddr  = addr;
    reqWdata = wdata;
    reqBe    = be;
  endtask

  task automatic applyResponse(input logic valid, input logic [7:0] source,
                               input logic [31:0] data, input logic err);
    tlD2h.d_valid  = valid;
    tlD2h.d_opcode = tlul_pkg::AccessAckData;
    tlD2h.d_source = source;
    tlD2h.d_data   = data;
    tlD2h.d_error  = err;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    // opcode, mask and data columns are worked out by hand from we/be
    vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, tlul_pkg::PutFullData,    4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1] = '{1'b1, 32'h14, 32'h0000ABCD, 4'h3, tlul_pkg::PutPartialData, 4'h3, 32'h0000ABCD, 32'h0,        1'b0};
    vecs[2] = '{1'b0, 32'h20, 32'h12345678, 4'h5, tlul_pkg::Get,            4'hF, 32'h0,        32'hCAFEF00D, 1'b0};
    vecs[3] = '{1'b1, 32'h24, 32'h00000055, 4'h0, tlul_pkg::PutPartialData, 4'h0, 32'h00000055, 32'h0,        1'b1};
    vecs[4] = '{1'b0, 32'h1C, 32'hFFFFFFFF, 4'hF, tlul_pkg::Get,            4'hF, 32'h0,        32'hA5A5A5A5, 1'b1};
    drainOrder = '{0, 1, 3, 2};

    rst      = 1'b1;
    rspReady = 1'b1;
    tlD2h    = '0;
    tlD2h.a_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    applyResponse(1'b0, 8'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_req_ready", reqReady, 0);
    checkOutput("rst_a_valid", tlH2d.a_valid, 0);
    checkOutput("rst_a_address", tlH2d.a_address, 0);
    checkOutput("rst_a_user", tlH2d.a_user, tlul_pkg::TL_A_USER_DEFAULT);
    checkOutput("rst_d_ready", tlH2d.d_ready, 1);
    checkOutput("rst_outstanding", outstanding, 0);
    checkOutput("rst_err_unexp", errUnexp, 0);
    checkOutput("rst_timeout", timeout, 0);
    rst = 1'b0;
    cycle();

    $display("[TB] single transaction table");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      #1;
      checkOutput($sformatf("v%0d_req_ready", i), reqReady, 1);
      cycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      expBeat                  = '0;
      expBeat.a_opcode         = vecs[i].expOp;
      expBeat.a_address        = vecs[i].addr;
      expBeat.a_mask           = vecs[i].expMask;
      expBeat.a_data           = vecs[i].expData;
      expBeat.a_user.instr_type = 4'h9;
      expBeat.a_user.data_intg = tlul_pkg::get_data_intg(vecs[i].expData);
      expBeat.a_user.cmd_intg  = tlul_pkg::get_cmd_intg(expBeat);
      checkOutput($sformatf("v%0d_a_valid", i), tlH2d.a_valid, 1);
      checkOutput($sformatf("v%0d_a_opcode", i), tlH2d.a_opcode, vecs[i].expOp);
      checkOutput($sformatf("v%0d_a_mask", i), tlH2d.a_mask, vecs[i].expMask);
      checkOutput($sformatf("v%0d_a_data", i), tlH2d.a_data, vecs[i].expData);
      checkOutput($sformatf("v%0d_a_address", i), tlH2d.a_address, vecs[i].addr);
      checkOutput($sformatf("v%0d_a_source", i), tlH2d.a_source, 0);
      checkOutput($sformatf("v%0d_a_size", i), tlH2d.a_size, 2);
      checkOutput($sformatf("v%0d_a_param", i), tlH2d.a_param, 0);
      checkOutput($sformatf("v%0d_data_intg", i), tlH2d.a_user.data_intg, expBeat.a_user.data_intg);
      checkOutput($sformatf("v%0d_cmd_intg", i), tlH2d.a_user.cmd_intg, expBeat.a_user.cmd_intg);
      checkOutput($sformatf("v%0d_outstanding1", i), outstanding, 1);
      applyResponse(1'b1, 8'h0, vecs[i].rdata, vecs[i].err);
      #1;
      checkOutput($sformatf("v%0d_rsp_valid", i), rspValid, 1);
      checkOutput($sformatf("v%0d_rsp_rdata", i), rspRdata, vecs[i].rdata);
      checkOutput($sformatf("v%0d_rsp_err", i), rspErr, vecs[i].err);
      checkOutput($sformatf("v%0d_rsp_source", i), rspSource, 0);
      cycle();
      applyResponse(1'b0, 8'h0, 32'h0, 1'b0);
      checkOutput($sformatf("v%0d_outstanding0", i), outstanding, 0);
      checkOutput($sformatf("v%0d_a_valid_idle", i), tlH2d.a_valid, 0);
      checkOutput($sformatf("v%0d_err_unexp", i), errUnexp, 0);
    end

    $display("[TB] back-to-back reads and full table");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 32'(k * 4), 32'h0, 4'h0);
      #1;
      checkOutput($sformatf("b2b%0d_ready", k), reqReady, 1);
      cycle();
      checkOutput($sformatf("b2b%0d_source", k), tlH2d.a_source, k);
      checkOutput($sformatf("b2b%0d_addr", k), tlH2d.a_address, k * 4);
      checkOutput($sformatf("b2b%0d_opcode", k), tlH2d.a_opcode, tlul_pkg::Get);
    end
    checkOutput("full_outstanding", outstanding, 4);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    #1;
    checkOutput("full_req_ready", reqReady, 0);
    cycle();
    checkOutput("full_a_valid", tlH2d.a_valid, 0);
    checkOutput("full_outstanding_hold", outstanding, 4);
    applyResponse(1'b1, 8'h2, 32'h22, 1'b0);
    #1;
    checkOutput("ooo_rsp_valid", rspValid, 1);
    checkOutput("ooo_rsp_source", rspSource, 2);
    checkOutput("ooo_rsp_rdata", rspRdata, 32'h22);
    checkOutput("ooo_no_same_cycle_reuse", reqReady, 0);
    cycle();
    applyResponse(1'b0, 8'h0, 32'h0, 1'b0);
    #1;
    checkOutput("ooo_outstanding3", outstanding, 3);
    checkOutput("ooo_req_ready", reqReady, 1);
    cycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("reuse_source", tlH2d.a_source, 2);
    checkOutput("reuse_addr", tlH2d.a_address, 32'h40);
    checkOutput("reuse_outstanding", outstanding, 4);
    applyResponse(1'b1, 8'h0, 32'h0, 1'b0);
    rspReady = 1'b0;
    #1;
    checkOutput("bp_d_ready", tlH2d.d_ready, 0);
    checkOutput("bp_rsp_valid", rspValid, 1);
    cycle();
    checkOutput("bp_outstanding", outstanding, 4);
    rspReady = 1'b1;
    for (int s = 0; s < 4; s++) begin
      applyResponse(1'b1, 8'(drainOrder[s]), 32'h0, 1'b0);
      cycle();
      checkOutput($sformatf("drain%0d_outstanding", s), outstanding, 3 - s);
    end
    applyResponse(1'b0, 8'h0, 32'h0, 1'b0);
    checkOutput("drain_err_unexp", errUnexp, 0);

    $display("[TB] a_ready stall");
    tlD2h.a_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'h30, 32'h11223344, 4'hF);
    #1;
    checkOutput("stall_accept", reqReady, 1);
    cycle();
    applyStimulus(1'b1, 1'b1, 32'h34, 32'h55667788, 4'hF);
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput($sformatf("stall%0d_req_ready", c), reqReady, 0);
      checkOutput($sformatf("stall%0d_a_valid", c), tlH2d.a_valid, 1);
      checkOutput($sformatf("stall%0d_addr", c), tlH2d.a_address, 32'h30);
      checkOutput($sformatf("stall%0d_data", c), tlH2d.a_data, 32'h11223344);
      checkOutput($sformatf("stall%0d_opcode", c), tlH2d.a_opcode, tlul_pkg::PutFullData);
      checkOutput($sformatf("stall%0d_outstanding", c), outstanding, 1);
      cycle();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tlD2h.a_ready = 1'b1;
    cycle();
    checkOutput("stall_one_beat", tlH2d.a_valid, 0);
    checkOutput("stall_outstanding", outstanding, 1);
    applyResponse(1'b1, 8'h0, 32'h0, 1'b0);
    cycle();
    applyResponse(1'b0, 8'h0, 32'h0, 1'b0);
    checkOutput("stall_drain", outstanding, 0);

    $display("[TB] unexpected D beats");
    applyResponse(1'b1, 8'h3, 32'hBAD, 1'b0);
    #1;
    checkOutput("unexp_rsp_valid", rspValid, 0);
    checkOutput("unexp_d_ready", tlH2d.d_ready, 1);
    cycle();
    applyResponse(1'b0, 8'h0, 32'h0, 1'b0);
    checkOutput("unexp_pulse", errUnexp, 1);
    cycle();
    checkOutput("unexp_pulse_end", errUnexp, 0);
    applyStimulus(1'b1, 1'b0, 32'h44, 32'h0, 4'h0);
    cycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    applyResponse(1'b1, 8'h10, 32'h0, 1'b0);
    #1;
    checkOutput("upper_rsp_valid", rspValid, 0);
    cycle();
    applyResponse(1'b0, 8'h0, 32'h0, 1'b0);
    checkOutput("upper_pulse", errUnexp, 1);
    checkOutput("upper_outstanding", outstanding, 1);
    applyResponse(1'b1, 8'h0, 32'h0, 1'b0);
    cycle();
    applyResponse(1'b0, 8'h0, 32'h0, 1'b0);
    checkOutput("upper_drain", outstanding, 0);
    checkOutput("upper_no_pulse", errUnexp, 0);

    $display("[TB] reset in flight");
    tlD2h.a_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h50, 32'h0, 4'h0);
    cycle();
    tlD2h.a_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h54, 32'h0, 4'h0);
    cycle();
    tlD2h.a_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("mid_outstanding", outstanding, 2);
    checkOutput("mid_a_valid", tlH2d.a_valid, 1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_outstanding", outstanding, 0);
    checkOutput("mid_rst_a_valid", tlH2d.a_valid, 0);
    checkOutput("mid_rst_req_ready", reqReady, 0);
    cycle();
    rst = 1'b0;
    tlD2h.a_ready = 1'b1;
    cycle();
    checkOutput("post_rst_outstanding", outstanding, 0);
    checkOutput("post_rst_a_valid", tlH2d.a_valid, 0);
    applyResponse(1'b1, 8'h0, 32'h0, 1'b0);
    #1;
    checkOutput("late_rsp_valid", rspValid, 0);
    cycle();
    applyResponse(1'b0, 8'h0, 32'h0, 1'b0);
    checkOutput("late_pulse", errUnexp, 1);

    $display("[TB] watchdog");
    applyStimulus(1'b1, 1'b0, 32'h60, 32'h0, 4'h0);
    cycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
`ifdef TLUL_HOST_ADAPTER_TIMEOUT_EN
    repeat (10) cycle();
    checkOutput("wd_early", timeout, 0);
    repeat (10) cycle();
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("wd_sticky%0d", c), timeout, 1);
      cycle();
    end
`else
    repeat (30) cycle();
    checkOutput("wd_disabled", timeout, 0);
`endif
    checkOutput("wd_no_abort", outstanding, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
